weight_stream_reader: RTL and testbench

//  Read-side partner of the neuron weight store. Holds a DEPTH x DATA_W weight RAM

---
 rtl/nn_pkg.sv | 14 +
 rtl/weight_ram.sv | 25 ++
 rtl/weight_stream_reader.sv | 130 +++++++++++++
 tb/tb_weight_stream_reader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared defaults and FSM state encoding for the neuron weight path.
package nn_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

endpackage

// File: rtl/weight_ram.sv
// Simple dual-port weight RAM: one write port, one synchronous read-first read port.
module weight_ram
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Non-blocking read and write in one process gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/weight_stream_reader.sv
// Streams a run of weights from the weight RAM over valid/ready through a 2-entry skid.
module weight_stream_reader
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_weights,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam int unsigned     ENT_W   = DATA_W + ADDR_W + 1;

  state_t state, next_state;

  logic [ADDR_W:0]   n_q, issued_q, n_clamped;
  logic [ADDR_W-1:0] base_q, rd_addr, rd_idx_q;
  logic              rd_last_q, inflight_q;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        count_q, occ;
  logic [ENT_W-1:0]  sk [2];
  logic [ENT_W-1:0]  new_ent;
  logic              accept, issue, pop, push;

  assign n_clamped = (num_weights > DEPTH_N) ? DEPTH_N : num_weights;
  assign accept    = (state == IDLE) && start;
  assign m_valid   = (count_q != 2'd0);
  assign pop       = m_valid && m_ready;
  assign push      = inflight_q;
  assign new_ent   = {rd_last_q, rd_idx_q, rd_data};
  assign rd_addr   = base_q + issued_q[ADDR_W-1:0];

  // Credit counts the slot freed by this cycle's pop, so a held-high m_ready sees no bubbles.
  assign occ   = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = (state == STREAM) && (issued_q < n_q) && (occ < 2'd2);

  assign {m_last, m_index, m_data} = sk[0];
  assign busy = accept || (state != IDLE);
  assign done = (state == FINISH);

  weight_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (n_clamped == '0) ? FINISH : STREAM;
      STREAM:  if (pop && m_last) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= '0;
      issued_q   <= '0;
      base_q     <= '0;
      inflight_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
      count_q    <= '0;
      sk[0]      <= '0;
      sk[1]      <= '0;
    end else begin
      if (accept) begin
        n_q      <= n_clamped;
        base_q   <= start_addr;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 1'b1;
      end

      inflight_q <= issue;
      if (issue) begin
        rd_idx_q  <= issued_q[ADDR_W-1:0];
        rd_last_q <= (issued_q == n_q - 1'b1);
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) sk[0] <= new_ent;
          else                 sk[1] <= new_ent;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          sk[0]   <= sk[1];
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            sk[0] <= new_ent;
          end else begin
            sk[0] <= sk[1];
            sk[1] <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_reader.sv
// Self-checking bench: table of stream runs plus hand-written reset and write-collision sequences.
module tb_weight_stream_reader;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, m_ready;
  logic [7:0] wr_addr, wr_data, start_addr;
  logic [8:0] num_weights;
  logic       m_valid, m_last, busy, done;
  logic [7:0] m_data, m_index;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [256];

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] i;
    logic       l;
  } beat_t;
  beat_t q[$];

  typedef struct {
    logic [7:0] sa;
    logic [8:0] n;
    int         mode;
    int         exp_done;
    int         exp_beats;
    int         poke;
  } vec_t;
  vec_t vt[5];

  always #5 clk = ~clk;

  weight_stream_reader #(.DATA_W(8), .DEPTH(256), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .start_addr  (start_addr),
    .num_weights (num_weights),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_index     (m_index),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head();
    if (q.size() == 0) begin
      check("extra_beat", {31'd0, m_valid}, 32'd0);
    end else begin
      check("m_data", {24'd0, m_data}, {24'd0, q[0].d});
      check("m_index", {24'd0, m_index}, {24'd0, q[0].i});
      check("m_last", {31'd0, m_last}, {31'd0, q[0].l});
    end
  endtask

  task automatic run_stream(input logic [7:0] sa, input logic [8:0] n, input int mode,
                            input int exp_done, input int exp_beats, input int poke_cyc,
                            input int wr_cyc, input logic [7:0] wr_a, input logic [7:0] wr_d,
                            input bit wr_vis);
    int neff, cyc, beats, first;
    bit finished;
    logic [3:0] pat;
    pat = 4'b1001;
    neff = (n > 9'd256) ? 256 : int'(n);
    if (wr_cyc > 0 && wr_vis) model[wr_a] = wr_d;
    q.delete();
    for (int k = 0; k < neff; k++)
      q.push_back('{d: model[(int'(sa) + k) % 256], i: 8'(k), l: (k == neff - 1)});
    if (wr_cyc > 0 && !wr_vis) model[wr_a] = wr_d;

    start = 1'b1; start_addr = sa; num_weights = n; m_ready = 1'b1;
    #1;
    check("busy_on_accept", {31'd0, busy}, 32'd1);
    cyc = 0; beats = 0; first = 0; finished = 1'b0;
    while (!finished && cyc < 2000) begin
      tick();
      cyc++;
      start = 1'b0;
      wr_en = 1'b0;
      if (m_valid) begin
        check_head();
        if (first == 0) first = cyc;
      end
      if (done) begin
        finished = 1'b1;
        if (exp_done != 0) check("done_cycle", cyc, exp_done);
        check("beat_count", beats, exp_beats);
        check("queue_empty", q.size(), 0);
      end
      check("busy_in_run", {31'd0, busy}, 32'd1);
      if (!finished) begin
        m_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
        if (m_valid && m_ready && q.size() > 0) begin
          void'(q.pop_front());
          beats++;
        end
        if (cyc == poke_cyc) begin
          start = 1'b1; start_addr = 8'd7; num_weights = 9'd1;
        end
        if (cyc == wr_cyc) begin
          wr_en = 1'b1; wr_addr = wr_a; wr_data = wr_d;
        end
      end
    end
    if (!finished) check("done_timeout", 32'd0, 32'd1);
    if (neff > 0 && mode == 0) check("first_valid_cycle", first, 3);
    tick();
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("valid_after_done", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    int cyc, beats;
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; m_ready = 1'b0;
    wr_addr = '0; wr_data = '0; start_addr = '0; num_weights = '0;
    repeat (3) tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_index", {24'd0, m_index}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(i) ^ 8'hA5;
      model[i] = 8'(i) ^ 8'hA5;
      tick();
    end
    wr_en = 1'b0;
    tick();

    vt[0] = '{8'd0,   9'd4,   0, 7,   4,   0};
    vt[1] = '{8'd254, 9'd4,   0, 7,   4,   0};
    vt[2] = '{8'd0,   9'd8,   1, 0,   8,   0};
    vt[3] = '{8'd10,  9'd0,   0, 1,   0,   0};
    vt[4] = '{8'd0,   9'd300, 0, 259, 256, 50};
    for (int v = 0; v < 5; v++)
      run_stream(vt[v].sa, vt[v].n, vt[v].mode, vt[v].exp_done, vt[v].exp_beats,
                 vt[v].poke, 0, 8'd0, 8'd0, 1'b0);

    // Write to address 5 while address 4 is read: new value visible.
    run_stream(8'd0, 9'd8, 0, 11, 8, 0, 5, 8'd5, 8'h3C, 1'b1);
    // Write to address 6 in the cycle it is read: old value returned.
    run_stream(8'd0, 9'd8, 0, 11, 8, 0, 7, 8'd6, 8'h5A, 1'b0);
    run_stream(8'd3, 9'd6, 0, 9, 6, 0, 0, 8'd0, 8'd0, 1'b0);

    // Abort a 16-beat run after the third handshake.
    q.delete();
    for (int k = 0; k < 16; k++) q.push_back('{d: model[k], i: 8'(k), l: (k == 15)});
    start = 1'b1; start_addr = 8'd0; num_weights = 9'd16; m_ready = 1'b1;
    cyc = 0; beats = 0;
    while (beats < 3 && cyc < 100) begin
      tick();
      cyc++;
      start = 1'b0;
      if (m_valid) begin
        check_head();
        void'(q.pop_front());
        beats++;
      end
    end
    check("abort_beats_seen", beats, 3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_m_valid", {31'd0, m_valid}, 32'd0);
    check("abort_m_data", {24'd0, m_data}, 32'd0);
    check("abort_m_index", {24'd0, m_index}, 32'd0);
    check("abort_m_last", {31'd0, m_last}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", {31'd0, done}, 32'd0);
      check("abort_no_valid", {31'd0, m_valid}, 32'd0);
    end
    run_stream(8'd20, 9'd2, 0, 5, 2, 0, 0, 8'd0, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
